readout_window_classifier: RTL and testbench

Parametrised successor to the single-shot readout classifier front end. Captures one trigger-delimited shot of I/Q samples from the QICK readout AXI-Stream and accumulates each of NUM_WINDOWS windows on the fly, with no sample memory. Presents the shifted window sums as a feature vector to an external NN core through a valid handshake, then writes the returned prediction to PL BRAM at a wrapping shot address. Sits between the readout block and the NN/BRAM, replacing the fixed 2-window load/compute/store wrapper.

---
 rtl/readout_pkg.sv | 44 ++++
 rtl/window_accumulator.sv | 46 ++++
 rtl/readout_window_classifier.sv | 256 +++++++++++++++++++++++++
 tb/tb_readout_window_classifier.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// readout_pkg
//   Shared definitions for the readout window classifier:
//   - controller state encoding
//   - derived width helpers (sample width after shift, accumulator width,
//     feature width)
//   - bit positions of the I and Q fields inside the 32-bit stream word
//   - prediction code written to BRAM when the NN core never answers
package readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT_NN = 3'd3,
    ST_STORE   = 3'd4
  } state_e;

  // Stream word layout: I in [31:18], Q in [17:4], [3:0] padding.
  localparam int TDATA_I_MSB = 31;
  localparam int TDATA_I_LSB = 18;
  localparam int TDATA_Q_MSB = 17;
  localparam int TDATA_Q_LSB = 4;

  // All-ones prediction marks a shot whose NN result timed out.
  localparam logic [31:0] TIMEOUT_PRED = '1;

  // Width of one sample after dropping SHIFT_M LSBs.
  function automatic int calc_iqw(input int iq_width_in, input int shift_m);
    return iq_width_in - shift_m;
  endfunction

  // Accumulator width: enough headroom for WINDOW_LEN signed samples.
  function automatic int calc_acc_w(input int iq_width_in, input int shift_m,
                                    input int window_len);
    return calc_iqw(iq_width_in, shift_m) + $clog2(window_len);
  endfunction

  // Feature width after dropping SHIFT_N LSBs of each window sum.
  function automatic int calc_feat_w(input int iq_width_in, input int shift_m,
                                     input int window_len, input int shift_n);
    return calc_acc_w(iq_width_in, shift_m, window_len) - shift_n;
  endfunction

endpackage

// File: rtl/window_accumulator.sv
// window_accumulator
//   Running signed sum of one channel (I or Q) over one window.
//   Ports:
//     ap_clk, ap_rst_n : clock, asynchronous active-low reset
//     clr              : synchronous clear of the sum (wins over en)
//     en               : add sample this cycle
//     sample [IQW]     : signed shifted sample, sign-extended before the add
//     acc [ACC_W]      : current sum
module window_accumulator #(
  parameter int IQW   = 5,
  parameter int ACC_W = 13
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [IQW-1:0]   sample,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W - IQW){sample[IQW-1]}}, sample};

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + sample_ext;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/readout_window_classifier.sv
// readout_window_classifier
//   Captures one trigger-delimited shot of I/Q samples, accumulates each of
//   NUM_WINDOWS windows on the fly, hands the shifted window sums to an NN
//   core and writes the returned prediction to BRAM at a wrapping address.
//   Ports:
//     ap_clk, ap_rst_n     : clock, asynchronous active-low reset
//     trigger              : shot start (level sampled in IDLE)
//     clear                : sync clear of write address, drop_count, timeout_flag
//     in_TDATA, in_TVALID  : readout stream (no back-pressure)
//     feat_data, feat_valid: feature vector and its one-cycle strobe
//     nn_pred, nn_pred_valid : NN result
//     out_ADDR/DATA/WE     : BRAM write port
//     busy                 : high whenever not IDLE
//     drop_count           : saturating count of triggers ignored while busy
//     timeout_flag         : sticky NN timeout indicator
//     dbg_state_o          : controller state for observation
//
//   Handshake semantics: the input stream has no ready, so every cycle with
//   in_TVALID=1 in ACCUM is a consumed sample; feat_valid is a single-cycle
//   strobe with no ready; nn_pred is taken on the first WAIT_NN cycle in which
//   nn_pred_valid=1 and ignored in every other state.
module readout_window_classifier
  import readout_pkg::*;
#(
  parameter int NUM_WINDOWS    = 2,
  parameter int WINDOW_LEN     = 200,
  parameter int IQ_WIDTH_IN    = 14,
  parameter int SHIFT_M        = 9,
  parameter int SHIFT_N        = 1,
  parameter int PRED_BITS      = 2,
  parameter int BRAM_ADDR_BITS = 14,
  parameter int NN_TIMEOUT     = 64
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      trigger,
  input  logic                      clear,
  input  logic [31:0]               in_TDATA,
  input  logic                      in_TVALID,
  output logic [2*NUM_WINDOWS*calc_feat_w(IQ_WIDTH_IN, SHIFT_M, WINDOW_LEN, SHIFT_N)-1:0] feat_data,
  output logic                      feat_valid,
  input  logic [PRED_BITS-1:0]      nn_pred,
  input  logic                      nn_pred_valid,
  output logic [BRAM_ADDR_BITS-1:0] out_ADDR,
  output logic [PRED_BITS-1:0]      out_DATA,
  output logic                      out_WE,
  output logic                      busy,
  output logic [15:0]               drop_count,
  output logic                      timeout_flag,
  output logic [2:0]                dbg_state_o
);

  localparam int IQW    = calc_iqw(IQ_WIDTH_IN, SHIFT_M);
  localparam int ACC_W  = calc_acc_w(IQ_WIDTH_IN, SHIFT_M, WINDOW_LEN);
  localparam int FEAT_W = calc_feat_w(IQ_WIDTH_IN, SHIFT_M, WINDOW_LEN, SHIFT_N);
  localparam int BUS_W  = 2 * NUM_WINDOWS * FEAT_W;
  localparam int CNT_W  = $clog2(WINDOW_LEN);
  localparam int WIN_W  = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;
  localparam int WAIT_W = $clog2(NN_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  LAST_SAMP = CNT_W'(WINDOW_LEN - 1);
  localparam logic [WIN_W-1:0]  LAST_WIN  = WIN_W'(NUM_WINDOWS - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(NN_TIMEOUT - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0]          samp_cnt_q, samp_cnt_d;
  logic [WIN_W-1:0]          win_idx_q, win_idx_d;
  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic [BUS_W-1:0]          feat_q, feat_d;
  logic [PRED_BITS-1:0]      pred_q, pred_d;
  logic [BRAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [15:0]               drop_q, drop_d;
  logic                      tflag_q, tflag_d;

  logic acc_clr;
  logic accept;
  logic shot_done;
  logic nn_timeout;

  logic [IQW-1:0] samp_i;
  logic [IQW-1:0] samp_q;

  logic [NUM_WINDOWS-1:0][ACC_W-1:0] acc_i_w;
  logic [NUM_WINDOWS-1:0][ACC_W-1:0] acc_q_w;
  logic [BUS_W-1:0]                  feat_pack;
  logic                              unused_bits;

  // Top IQW bits of each field == arithmetic shift right by SHIFT_M.
  assign samp_i = in_TDATA[TDATA_I_MSB -: IQW];
  assign samp_q = in_TDATA[TDATA_Q_MSB -: IQW];

  assign shot_done  = (samp_cnt_q == LAST_SAMP) && (win_idx_q == LAST_WIN);
  assign nn_timeout = (wait_cnt_q == LAST_WAIT);

  // One I and one Q accumulator per window; only the window selected by
  // win_idx_q sees enable, so a sample can never land in another window.
  for (genvar w = 0; w < NUM_WINDOWS; w++) begin : g_win
    logic win_en;
    assign win_en = accept && (win_idx_q == WIN_W'(w));

    window_accumulator #(.IQW(IQW), .ACC_W(ACC_W)) u_acc_i (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clr      (acc_clr),
      .en       (win_en),
      .sample   (samp_i),
      .acc      (acc_i_w[w])
    );

    window_accumulator #(.IQW(IQW), .ACC_W(ACC_W)) u_acc_q (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .clr      (acc_clr),
      .en       (win_en),
      .sample   (samp_q),
      .acc      (acc_q_w[w])
    );

    assign feat_pack[(2*w)*FEAT_W +: FEAT_W]   = acc_i_w[w][ACC_W-1:SHIFT_N];
    assign feat_pack[(2*w+1)*FEAT_W +: FEAT_W] = acc_q_w[w][ACC_W-1:SHIFT_N];
  end

  // Padding bits of the stream word and the dropped sum LSBs are not needed.
  assign unused_bits = ^{in_TDATA, acc_i_w, acc_q_w};

  // Controller next-state
  always_comb begin
    state_d = state_q;
    acc_clr = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d = ST_ACCUM;
          acc_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (in_TVALID) begin
          accept = 1'b1;
          if (shot_done) begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_NN;
      end
      ST_WAIT_NN: begin
        if (nn_pred_valid || nn_timeout) begin
          state_d = ST_STORE;
        end
      end
      ST_STORE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters and output registers next-state
  always_comb begin
    samp_cnt_d = samp_cnt_q;
    win_idx_d  = win_idx_q;
    wait_cnt_d = wait_cnt_q;
    feat_d     = feat_q;
    pred_d     = pred_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    tflag_d    = tflag_q;

    if (acc_clr) begin
      samp_cnt_d = '0;
      win_idx_d  = '0;
    end else if (accept) begin
      if (samp_cnt_q == LAST_SAMP) begin
        samp_cnt_d = '0;
        win_idx_d  = (win_idx_q == LAST_WIN) ? '0 : win_idx_q + 1'b1;
      end else begin
        samp_cnt_d = samp_cnt_q + 1'b1;
      end
    end

    if (state_q == ST_ISSUE) begin
      feat_d     = feat_pack;
      wait_cnt_d = '0;
    end

    if (state_q == ST_WAIT_NN) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
      // A result arriving on the timeout cycle still wins.
      if (nn_pred_valid) begin
        pred_d = nn_pred;
      end else if (nn_timeout) begin
        pred_d  = TIMEOUT_PRED[PRED_BITS-1:0];
        tflag_d = 1'b1;
      end
    end

    if (trigger && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    // The STORE write itself uses addr_q; clear only affects what follows.
    if (state_q == ST_STORE) begin
      addr_d = addr_q + 1'b1;
    end

    if (clear) begin
      addr_d  = '0;
      drop_d  = '0;
      tflag_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= ST_IDLE;
      samp_cnt_q <= '0;
      win_idx_q  <= '0;
      wait_cnt_q <= '0;
      feat_q     <= '0;
      pred_q     <= '0;
      addr_q     <= '0;
      drop_q     <= '0;
      tflag_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      win_idx_q  <= win_idx_d;
      wait_cnt_q <= wait_cnt_d;
      feat_q     <= feat_d;
      pred_q     <= pred_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      tflag_q    <= tflag_d;
    end
  end

  // In ISSUE the accumulators already hold the final sums (they are
  // registers), so they drive the bus directly; feat_q holds the same value
  // from the next cycle until the following ISSUE.
  assign feat_data    = (state_q == ST_ISSUE) ? feat_pack : feat_q;
  assign feat_valid   = (state_q == ST_ISSUE);
  assign out_WE       = (state_q == ST_STORE);
  assign busy         = (state_q != ST_IDLE);
  assign out_ADDR     = addr_q;
  assign out_DATA     = pred_q;
  assign drop_count   = drop_q;
  assign timeout_flag = tflag_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_readout_window_classifier.sv
module tb_readout_window_classifier;

  localparam int NW = 2;
  localparam int WL = 200;
  localparam int NS = NW * WL;
  localparam int AB = 2;
  localparam int TO = 64;

  localparam logic [47:0] FEAT_CONST = {12'hF9C, 12'd100, 12'hF9C, 12'd100};
  localparam logic [47:0] FEAT_GAP   = {12'h000, 12'hF9C, 12'h000, 12'd100};
  localparam logic [31:0] GARBAGE    = {14'h2000, 14'h1E00, 4'hF};

  logic          ap_clk;
  logic          ap_rst_n;
  logic          trigger;
  logic          clear;
  logic [31:0]   in_TDATA;
  logic          in_TVALID;
  logic [47:0]   feat_data;
  logic          feat_valid;
  logic [1:0]    nn_pred;
  logic          nn_pred_valid;
  logic [AB-1:0] out_ADDR;
  logic [1:0]    out_DATA;
  logic          out_WE;
  logic          busy;
  logic [15:0]   drop_count;
  logic          timeout_flag;
  logic [2:0]    dbg_state_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AB-1:0] wr_addr_log[$];
  logic [1:0]    wr_data_log[$];

  readout_window_classifier #(
    .NUM_WINDOWS(NW), .WINDOW_LEN(WL), .IQ_WIDTH_IN(14), .SHIFT_M(9),
    .SHIFT_N(1), .PRED_BITS(2), .BRAM_ADDR_BITS(AB), .NN_TIMEOUT(TO)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .trigger       (trigger),
    .clear         (clear),
    .in_TDATA      (in_TDATA),
    .in_TVALID     (in_TVALID),
    .feat_data     (feat_data),
    .feat_valid    (feat_valid),
    .nn_pred       (nn_pred),
    .nn_pred_valid (nn_pred_valid),
    .out_ADDR      (out_ADDR),
    .out_DATA      (out_DATA),
    .out_WE        (out_WE),
    .busy          (busy),
    .drop_count    (drop_count),
    .timeout_flag  (timeout_flag),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock / reset block
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Every BRAM write is logged so aborted shots can be shown to write nothing.
  always @(negedge ap_clk) begin
    if (out_WE === 1'b1) begin
      wr_addr_log.push_back(out_ADDR);
      wr_data_log.push_back(out_DATA);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // mode 0: I=+1, Q=-1 everywhere; mode 1: I=+1 in window 0, I=-1 in window 1, Q=0
  function automatic logic [31:0] sample_word(input int mode, input int k);
    logic [13:0] iv;
    logic [13:0] qv;
    if (mode == 0) begin
      iv = 14'h0200;
      qv = 14'h3E00;
    end else begin
      iv = (k < WL) ? 14'h0200 : 14'h3E00;
      qv = 14'h0000;
    end
    return {iv, qv, 4'h5};
  endfunction

  // Driver: caller is just after a posedge. Returns just after the posedge
  // following the BRAM write (controller back in IDLE).
  task automatic run_shot(input int mode, input bit gapped, input bit respond,
                          input logic [1:0] pred, input bit inject,
                          output logic [47:0] f_data, output int f_rel,
                          output int w_rel, output logic [AB-1:0] w_addr,
                          output logic [1:0] w_data);
    int  c0;
    int  n;
    bit  got;
    c0 = cyc;
    f_rel = -1;
    w_rel = -1;
    f_data = '0;
    w_addr = '0;
    w_data = '0;
    trigger = 1'b1;
    in_TVALID = 1'b1;
    in_TDATA = GARBAGE;
    @(posedge ap_clk); #1;
    for (int k = 0; k < NS; k++) begin
      if (gapped) begin
        trigger = 1'b0;
        in_TVALID = 1'b0;
        in_TDATA = GARBAGE;
        @(posedge ap_clk); #1;
      end
      if (inject && (k == 10 || k == 100 || k == 300)) begin
        trigger = 1'b1;
        nn_pred_valid = 1'b1;
        nn_pred = 2'b01;
      end else begin
        trigger = 1'b0;
        nn_pred_valid = 1'b0;
      end
      in_TVALID = 1'b1;
      in_TDATA = sample_word(mode, k);
      @(posedge ap_clk); #1;
    end
    trigger = 1'b0;
    nn_pred_valid = 1'b0;
    in_TVALID = 1'b0;
    in_TDATA = GARBAGE;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge ap_clk);
      if (feat_valid === 1'b1) begin
        got = 1'b1;
        f_rel = cyc - c0;
        f_data = feat_data;
      end
      @(posedge ap_clk); #1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL feat_valid_seen got none exp pulse within 20 cycles");
    end
    if (respond) begin
      nn_pred_valid = 1'b1;
      nn_pred = pred;
      @(posedge ap_clk); #1;
      nn_pred_valid = 1'b0;
    end
    got = 1'b0;
    n = 0;
    while (!got && n < TO + 10) begin
      @(negedge ap_clk);
      if (out_WE === 1'b1) begin
        got = 1'b1;
        w_rel = cyc - c0;
        w_addr = out_ADDR;
        w_data = out_DATA;
      end
      @(posedge ap_clk); #1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bram_write_seen got none exp one write within %0d cycles", TO + 10);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge ap_clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if ({out_ADDR, out_DATA, out_WE, feat_data, feat_valid, busy, drop_count,
         timeout_flag, dbg_state_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%h data=%h we=%b feat=%h fv=%b busy=%b drop=%0d tf=%b st=%0d exp all 0",
               out_ADDR, out_DATA, out_WE, feat_data, feat_valid, busy, drop_count, timeout_flag, dbg_state_o);
    end
    #2 ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_constant();
    logic [47:0]   fd;
    int            fr, wr;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    run_shot(0, 1'b0, 1'b1, 2'b10, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if (fr !== 401) begin errors++; $display("FAIL const_feat_cycle got %0d exp 401", fr); end
    checks++;
    if (fd !== FEAT_CONST) begin errors++; $display("FAIL const_feat_data got %h exp %h", fd, FEAT_CONST); end
    checks++;
    if (wr !== 403) begin errors++; $display("FAIL const_write_cycle got %0d exp 403", wr); end
    checks++;
    if ({wa, wd} !== {2'd0, 2'b10}) begin
      errors++; $display("FAIL const_write got addr=%0d data=%b exp addr=0 data=10", wa, wd);
    end
    @(negedge ap_clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL const_idle_busy got %b exp 0", busy); end
    checks++;
    if (feat_data !== FEAT_CONST) begin errors++; $display("FAIL const_feat_hold got %h exp %h", feat_data, FEAT_CONST); end
    checks++;
    if ({drop_count, timeout_flag} !== 17'd0) begin
      errors++; $display("FAIL const_status got drop=%0d tf=%b exp 0 0", drop_count, timeout_flag);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_gapped();
    logic [47:0]   fd;
    int            fr, wr;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    run_shot(1, 1'b1, 1'b1, 2'b01, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if (fd !== FEAT_GAP) begin errors++; $display("FAIL gap_feat_data got %h exp %h", fd, FEAT_GAP); end
    checks++;
    if (fr !== 801) begin errors++; $display("FAIL gap_feat_cycle got %0d exp 801", fr); end
    checks++;
    if ({wa, wd} !== {2'd1, 2'b01}) begin
      errors++; $display("FAIL gap_write got addr=%0d data=%b exp addr=1 data=01", wa, wd);
    end
  endtask

  task automatic test_timeout();
    logic [47:0]   fd;
    int            fr, wr;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    run_shot(0, 1'b0, 1'b0, 2'b00, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if (wr !== 401 + 1 + TO) begin errors++; $display("FAIL to_write_cycle got %0d exp %0d", wr, 401 + 1 + TO); end
    checks++;
    if ({wa, wd} !== {2'd2, 2'b11}) begin
      errors++; $display("FAIL to_write got addr=%0d data=%b exp addr=2 data=11", wa, wd);
    end
    checks++;
    if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag_set got %b exp 1", timeout_flag); end
    // A normal shot must leave the sticky flag alone.
    run_shot(0, 1'b0, 1'b1, 2'b01, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if ({wa, wd} !== {2'd3, 2'b01}) begin
      errors++; $display("FAIL to_next_write got addr=%0d data=%b exp addr=3 data=01", wa, wd);
    end
    checks++;
    if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag_sticky got %b exp 1", timeout_flag); end
    do_clear();
    @(negedge ap_clk);
    checks++;
    if ({timeout_flag, out_ADDR} !== 3'd0) begin
      errors++; $display("FAIL to_clear got tf=%b addr=%0d exp 0 0", timeout_flag, out_ADDR);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_trigger_busy();
    logic [47:0]   fd;
    int            fr, wr, n0;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    n0 = wr_addr_log.size();
    run_shot(0, 1'b0, 1'b1, 2'b10, 1'b1, fd, fr, wr, wa, wd);
    checks++;
    if (drop_count !== 16'd3) begin errors++; $display("FAIL busy_drop_count got %0d exp 3", drop_count); end
    checks++;
    if (wr_addr_log.size() !== n0 + 1) begin
      errors++; $display("FAIL busy_write_count got %0d exp %0d", wr_addr_log.size(), n0 + 1);
    end
    checks++;
    if ({wa, wd} !== {2'd0, 2'b10}) begin
      errors++; $display("FAIL busy_write got addr=%0d data=%b exp addr=0 data=10", wa, wd);
    end
    // Trigger on the very first IDLE cycle after STORE must start a shot.
    run_shot(0, 1'b0, 1'b1, 2'b01, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if (fr !== 401) begin errors++; $display("FAIL b2b_feat_cycle got %0d exp 401", fr); end
    checks++;
    if ({drop_count, wa, wd} !== {16'd3, 2'd1, 2'b01}) begin
      errors++; $display("FAIL b2b_status got drop=%0d addr=%0d data=%b exp 3 1 01", drop_count, wa, wd);
    end
  endtask

  task automatic test_addr_wrap();
    logic [47:0]   fd;
    int            fr, wr;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    logic [AB-1:0] exp_addr[5];
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_clear();
    for (int s = 0; s < 5; s++) begin
      run_shot(0, 1'b0, 1'b1, 2'b10, 1'b0, fd, fr, wr, wa, wd);
      checks++;
      if (wa !== exp_addr[s]) begin
        errors++; $display("FAIL wrap_addr shot %0d got %0d exp %0d", s, wa, exp_addr[s]);
      end
    end
    @(negedge ap_clk);
    checks++;
    if (out_ADDR !== 2'd1) begin errors++; $display("FAIL wrap_after got %0d exp 1", out_ADDR); end
    @(posedge ap_clk); #1;
    do_clear();
    @(negedge ap_clk);
    checks++;
    if ({out_ADDR, drop_count} !== 18'd0) begin
      errors++; $display("FAIL wrap_clear got addr=%0d drop=%0d exp 0 0", out_ADDR, drop_count);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [47:0]   fd;
    int            fr, wr, n0;
    logic [AB-1:0] wa;
    logic [1:0]    wd;
    run_shot(0, 1'b0, 1'b1, 2'b10, 1'b0, fd, fr, wr, wa, wd);
    n0 = wr_addr_log.size();
    trigger = 1'b1;
    in_TVALID = 1'b1;
    in_TDATA = GARBAGE;
    @(posedge ap_clk); #1;
    for (int k = 0; k < 150; k++) begin
      trigger = (k == 10);
      in_TDATA = sample_word(0, k);
      @(posedge ap_clk); #1;
    end
    trigger = 1'b0;
    in_TVALID = 1'b0;
    checks++;
    if ({busy, drop_count, out_ADDR} !== {1'b1, 16'd1, 2'd1}) begin
      errors++; $display("FAIL mid_pre_state got busy=%b drop=%0d addr=%0d exp 1 1 1", busy, drop_count, out_ADDR);
    end
    #2 ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++;
    if ({out_ADDR, out_DATA, out_WE, feat_data, feat_valid, busy, drop_count, timeout_flag} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got addr=%h data=%h we=%b feat=%h fv=%b busy=%b drop=%0d tf=%b exp all 0",
               out_ADDR, out_DATA, out_WE, feat_data, feat_valid, busy, drop_count, timeout_flag);
    end
    ap_rst_n = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
    checks++;
    if (wr_addr_log.size() !== n0) begin
      errors++; $display("FAIL mid_no_write got %0d writes exp %0d", wr_addr_log.size(), n0);
    end
    run_shot(0, 1'b0, 1'b1, 2'b01, 1'b0, fd, fr, wr, wa, wd);
    checks++;
    if (fd !== FEAT_CONST) begin errors++; $display("FAIL mid_fresh_feat got %h exp %h", fd, FEAT_CONST); end
    checks++;
    if ({wa, wd} !== {2'd0, 2'b01}) begin
      errors++; $display("FAIL mid_fresh_write got addr=%0d data=%b exp addr=0 data=01", wa, wd);
    end
  endtask

  initial begin
    trigger = 1'b0;
    clear = 1'b0;
    in_TDATA = '0;
    in_TVALID = 1'b0;
    nn_pred = 2'b00;
    nn_pred_valid = 1'b0;
    test_reset();
    test_constant();
    test_gapped();
    test_timeout();
    test_trigger_busy();
    test_addr_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
